// File: rtl/mcu_spi_pkg.sv
// Shared types and constants for the MCU SPI target.
package mcu_spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        STALLED = 2'd2
    } spi_state_t;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_TIMEOUT_W = 16;
    localparam logic [SPI_BYTE_W-1:0] SPI_FIRST_TX_BYTE = 8'h00;

endpackage

// File: rtl/mcu_spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall detection
// from a single history flop behind the last synchroniser stage.
module mcu_spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    // Resetting to 0 means a chip select held low across reset is never seen
    // as a falling edge, so the MCU must re-frame.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/mcu_spi.sv
// SPI mode-0 target bridging the board MCU to the system-control byte interface.
// Optional frame timeout enabled by defining MCU_SPI_TIMEOUT_EN.
module mcu_spi
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_csn,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  data_in_strobe,
    output logic                  data_in_start,
    output logic [SPI_BYTE_W-1:0] data_in,
    input  logic [SPI_BYTE_W-1:0] data_out,
    output logic                  frame_active,
    output logic                  frame_abort
);

    spi_state_t state, state_nxt;

    logic csn_rise, csn_fall, sck_rise, sck_fall, mosi_s;
    logic csn_s, sck_s;
    logic sck_rise_act, sck_fall_act, timeout;

    logic [SPI_BYTE_W-1:0] rx_sr, tx_sr;
    logic [2:0]            bit_cnt;
    logic                  first, byte_done;

    mcu_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_csn (
        .clk(clk), .reset(reset), .din(spi_csn),
        .sync(csn_s), .rise(csn_rise), .fall(csn_fall)
    );

    mcu_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .reset(reset), .din(spi_sck),
        .sync(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    mcu_spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(spi_mosi),
        .sync(mosi_s), .rise(), .fall()
    );

    // A chip-select rise always wins over a coincident SCK edge.
    assign sck_rise_act = (state == ACTIVE) && sck_rise && !csn_rise;
    assign sck_fall_act = (state == ACTIVE) && sck_fall && !csn_rise;

`ifdef MCU_SPI_TIMEOUT_EN
    localparam logic [SPI_TIMEOUT_W-1:0] TIMEOUT_LAST = SPI_TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [SPI_TIMEOUT_W-1:0] idle_cnt;

    assign timeout = (state == ACTIVE) && !csn_rise && !sck_rise && !sck_fall
                     && (idle_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (state != ACTIVE || sck_rise || sck_fall) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (csn_fall) state_nxt = ACTIVE;
            ACTIVE: begin
                if (csn_rise)     state_nxt = IDLE;
                else if (timeout) state_nxt = STALLED;
            end
            STALLED: if (csn_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_active = 1'b0;
        spi_miso_oe  = 1'b0;
        if (state == ACTIVE) begin
            frame_active = 1'b1;
            spi_miso_oe  = 1'b1;
        end
    end

    assign spi_miso = tx_sr[SPI_BYTE_W-1];

    // NOTE: the shift registers are cleared on reset too, so MISO and
    // data_in read back 0 rather than stale bytes after a mid-frame reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sr          <= '0;
            tx_sr          <= '0;
            bit_cnt        <= '0;
            first          <= 1'b0;
            byte_done      <= 1'b0;
            data_in        <= '0;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            frame_abort    <= 1'b0;
        end else begin
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            frame_abort    <= 1'b0;
            if (state == IDLE && csn_fall) begin
                bit_cnt   <= '0;
                first     <= 1'b1;
                byte_done <= 1'b0;
                tx_sr     <= SPI_FIRST_TX_BYTE;
            end else if (sck_rise_act) begin
                rx_sr   <= {rx_sr[SPI_BYTE_W-2:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    data_in        <= {rx_sr[SPI_BYTE_W-2:0], mosi_s};
                    data_in_strobe <= 1'b1;
                    data_in_start  <= first;
                    first          <= 1'b0;
                    byte_done      <= 1'b1;
                end
            end else if (sck_fall_act) begin
                if (byte_done) begin
                    tx_sr     <= data_out;
                    byte_done <= 1'b0;
                end else begin
                    tx_sr <= {tx_sr[SPI_BYTE_W-2:0], 1'b0};
                end
            end else if (timeout) begin
                bit_cnt     <= '0;
                frame_abort <= 1'b1;
            end
        end
    end

    // Synchronised levels are only needed for edge detection.
    logic unused_levels;
    assign unused_levels = csn_s ^ sck_s;

endmodule
